// File: rtl/issue_scoreboard.sv
// Issue slot between decode and the functional units: holds one uop, tracks
// pending register writes in a busy scoreboard and stalls on RAW/WAW hazards.
package Uop;
  typedef enum logic [1:0] {
    EX_NONE    = 2'd0,
    EX_DECODE  = 2'd1,
    EX_ILLEGAL = 2'd2
  } ex_t;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_ADD   = 4'd1;
  localparam logic [3:0] OP_ADDI  = 4'd2;
  localparam logic [3:0] OP_STORE = 4'd3;

  typedef struct packed {
    logic [3:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [11:0] imm;
    ex_t         ex;
  } dec_t;
endpackage

module issue_scoreboard #(
  parameter  int NUM_REGS = 32,
  localparam int RW       = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inValid,
  output logic                inReady,
  input  Uop::dec_t           inDec,
  output logic                outValid,
  input  logic                outReady,
  output Uop::dec_t           outDec,
  input  logic                wbValid,
  input  logic [RW-1:0]       wbRd,
  input  logic                flush,
  output logic [NUM_REGS-1:0] busyRegs,
  output logic                drained
);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    HELD    = 2'd1,
    BLOCKED = 2'd2
  } state_t;

  state_t              state_reg, state_next;
  Uop::dec_t           out_dec_reg;
  logic [NUM_REGS-1:0] busy_reg, busy_next;
  logic                hazard, exc_held, fire, accept;

  // Hazard looks only at the registered scoreboard; a writeback this cycle
  // does not unblock the held uop until the next cycle.
  assign hazard   = busy_reg[out_dec_reg.rs1[RW-1:0]]
                  | busy_reg[out_dec_reg.rs2[RW-1:0]]
                  | busy_reg[out_dec_reg.rd[RW-1:0]];
  assign exc_held = (out_dec_reg.ex != Uop::EX_NONE);

  always_comb begin
    state_next = state_reg;
    outValid   = 1'b0;
    inReady    = 1'b0;
    fire       = 1'b0;
    case (state_reg)
      EMPTY: inReady = !flush;
      HELD: begin
        outValid = !flush && (exc_held || !hazard);
        fire     = outValid && outReady;
        // An excepting uop parks the slot in BLOCKED, so no refill behind it.
        inReady  = fire && !exc_held;
        if (fire) state_next = exc_held ? BLOCKED : EMPTY;
      end
      BLOCKED: state_next = BLOCKED;
      default: state_next = EMPTY;
    endcase
    accept = inValid && inReady;
    if (accept) state_next = HELD;
    if (flush)  state_next = EMPTY;
  end

  // Per-register scoreboard update; a same-cycle reservation beats a release.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_busy
      if (gi == 0) begin : g_zero
        assign busy_next[gi] = 1'b0;
      end else begin : g_reg
        logic set_hit, clr_hit;
        assign set_hit = fire && !exc_held && (out_dec_reg.rd[RW-1:0] == RW'(gi));
        assign clr_hit = wbValid && (wbRd == RW'(gi));
        assign busy_next[gi] = set_hit || (busy_reg[gi] && !clr_hit);
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= EMPTY;
      busy_reg    <= '0;
      out_dec_reg <= '0;
    end else begin
      state_reg <= state_next;
      busy_reg  <= busy_next;
      if (accept) out_dec_reg <= inDec;
    end
  end

  assign outDec   = out_dec_reg;
  assign busyRegs = busy_reg;
  assign drained  = (state_reg == EMPTY) && (busy_reg == '0);

endmodule

// File: tb/tb_issue_scoreboard.sv
// Bench for issue_scoreboard: directed vector table, hand-written corner
// sequences, then random traffic against an abstract slot/scoreboard model.
module tb_issue_scoreboard;
  import Uop::*;

  logic        clk = 1'b0;
  logic        rst, inValid, inReady, outValid, outReady, wbValid, flush, drained;
  dec_t        inDec, outDec;
  logic [4:0]  wbRd;
  logic [31:0] busyRegs;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  issue_scoreboard #(.NUM_REGS(32)) dut (
    .clk(clk), .rst(rst), .inValid(inValid), .inReady(inReady), .inDec(inDec),
    .outValid(outValid), .outReady(outReady), .outDec(outDec),
    .wbValid(wbValid), .wbRd(wbRd), .flush(flush),
    .busyRegs(busyRegs), .drained(drained)
  );

  function automatic dec_t mk(logic [3:0] op, int rd, int rs1, int rs2, ex_t ex);
    dec_t d;
    d.op  = op;
    d.rd  = 5'(rd);
    d.rs1 = 5'(rs1);
    d.rs2 = 5'(rs2);
    d.imm = 12'(op * 17 + rd);
    d.ex  = ex;
    return d;
  endfunction

  function automatic dec_t add(int rd, int rs1, int rs2);
    return mk(OP_ADD, rd, rs1, rs2, EX_NONE);
  endfunction

  function automatic dec_t addi(int rd);
    return mk(OP_ADDI, rd, 0, 0, EX_NONE);
  endfunction

  // Drive one cycle's inputs after the falling edge, then let outputs settle.
  task automatic cyc(input logic r, input logic iv, input dec_t d, input logic ordy,
                     input logic wbv, input int wr, input logic fl);
    @(negedge clk);
    rst = r; inValid = iv; inDec = d; outReady = ordy;
    wbValid = wbv; wbRd = 5'(wr); flush = fl;
    #1;
  endtask

  task automatic check(input string nm, input logic eov, input logic eir, input logic edr,
                       input logic [31:0] eb, input logic dchk, input dec_t ed);
    vectors++;
    if (outValid !== eov || inReady !== eir || drained !== edr || busyRegs !== eb ||
        (dchk && outDec !== ed)) begin
      miscompares++;
      $display("FAIL %s: got outValid=%0b inReady=%0b drained=%0b busy=%h outDec=%h, want outValid=%0b inReady=%0b drained=%0b busy=%h outDec=%h%s",
               nm, outValid, inReady, drained, busyRegs, outDec, eov, eir, edr, eb, ed,
               dchk ? "" : "(unchecked)");
    end
  endtask

  task automatic chk(input string nm, input logic eov, input logic eir, input logic edr,
                     input logic [31:0] eb);
    check(nm, eov, eir, edr, eb, 1'b0, '0);
  endtask

  typedef struct {
    logic        iv;
    dec_t        dec;
    logic        ordy;
    logic        wbv;
    int          wbrd;
    logic        fl;
    logic        eov, eir, edr;
    logic [31:0] ebusy;
  } vec_t;

  function automatic vec_t row(logic iv, dec_t d, logic ordy, logic wbv, int wr, logic fl,
                               logic eov, logic eir, logic edr, logic [31:0] eb);
    vec_t v;
    v.iv = iv; v.dec = d; v.ordy = ordy; v.wbv = wbv; v.wbrd = wr; v.fl = fl;
    v.eov = eov; v.eir = eir; v.edr = edr; v.ebusy = eb;
    return v;
  endfunction

  vec_t tbl[19];

  // Abstract reference: slot occupancy, blocked flag, last accepted uop, busy set.
  bit   m_have, m_blocked;
  dec_t m_dec;
  bit   m_busy[32];

  initial begin
    dec_t nd, d;
    logic r, iv, ordy, wbv, fl, eov, eir, edr, hz, exc, fire;
    logic [31:0] eb;
    int wr;

    nd = '0;
    // ADD dependency chain, then four independent ADDIs back to back.
    tbl[0]  = row(1, add(3,1,2), 1, 0, 0, 0,  0, 1, 1, 32'h0);
    tbl[1]  = row(1, add(4,3,1), 1, 0, 0, 0,  1, 1, 0, 32'h0);
    tbl[2]  = row(0, nd,         1, 0, 0, 0,  0, 0, 0, 32'h8);
    tbl[3]  = row(0, nd,         1, 0, 0, 0,  0, 0, 0, 32'h8);
    tbl[4]  = row(0, nd,         1, 1, 3, 0,  0, 0, 0, 32'h8);
    tbl[5]  = row(0, nd,         1, 0, 0, 0,  1, 1, 0, 32'h0);
    tbl[6]  = row(0, nd,         1, 0, 0, 0,  0, 1, 0, 32'h10);
    tbl[7]  = row(0, nd,         1, 1, 4, 0,  0, 1, 0, 32'h10);
    tbl[8]  = row(0, nd,         1, 0, 0, 0,  0, 1, 1, 32'h0);
    tbl[9]  = row(1, addi(5),    1, 0, 0, 0,  0, 1, 1, 32'h0);
    tbl[10] = row(1, addi(6),    1, 0, 0, 0,  1, 1, 0, 32'h0);
    tbl[11] = row(1, addi(7),    1, 0, 0, 0,  1, 1, 0, 32'h20);
    tbl[12] = row(1, addi(8),    1, 0, 0, 0,  1, 1, 0, 32'h60);
    tbl[13] = row(0, nd,         1, 0, 0, 0,  1, 1, 0, 32'hE0);
    tbl[14] = row(0, nd,         1, 1, 5, 0,  0, 1, 0, 32'h1E0);
    tbl[15] = row(0, nd,         1, 1, 6, 0,  0, 1, 0, 32'h1C0);
    tbl[16] = row(0, nd,         1, 1, 7, 0,  0, 1, 0, 32'h180);
    tbl[17] = row(0, nd,         1, 1, 8, 0,  0, 1, 0, 32'h100);
    tbl[18] = row(0, nd,         1, 0, 0, 0,  0, 1, 1, 32'h0);

    cyc(1, 0, nd, 0, 0, 0, 0);
    cyc(0, 0, nd, 0, 0, 0, 0);
    check("reset", 0, 1, 1, 32'h0, 1'b1, '0);

    foreach (tbl[i]) begin
      cyc(0, tbl[i].iv, tbl[i].dec, tbl[i].ordy, tbl[i].wbv, tbl[i].wbrd, tbl[i].fl);
      chk($sformatf("table[%0d]", i), tbl[i].eov, tbl[i].eir, tbl[i].edr, tbl[i].ebusy);
    end

    // Store waits on r3 and reserves nothing when it issues.
    cyc(0, 1, addi(3), 1, 0, 0, 0);                        chk("st_a", 0, 1, 1, 32'h0);
    cyc(0, 1, mk(OP_STORE,0,2,3,EX_NONE), 1, 0, 0, 0);     chk("st_b", 1, 1, 0, 32'h0);
    cyc(0, 0, nd, 1, 0, 0, 0);                             chk("st_stall", 0, 0, 0, 32'h8);
    cyc(0, 0, nd, 1, 1, 3, 0);                             chk("st_wb", 0, 0, 0, 32'h8);
    cyc(0, 0, nd, 1, 0, 0, 0);                             chk("st_issue", 1, 1, 0, 32'h0);
    cyc(0, 0, nd, 1, 0, 0, 0);                             chk("st_done", 0, 1, 1, 32'h0);

    // Decode exception issues despite a busy source, then blocks until flush.
    cyc(0, 1, addi(2), 1, 0, 0, 0);                        chk("ex_a", 0, 1, 1, 32'h0);
    cyc(0, 1, mk(OP_ADD,6,2,0,EX_DECODE), 1, 0, 0, 0);     chk("ex_b", 1, 1, 0, 32'h0);
    cyc(0, 1, addi(9), 1, 0, 0, 0);                        chk("ex_issue", 1, 0, 0, 32'h4);
    for (int k = 0; k < 10; k++) begin
      cyc(0, 1, addi(9), 1, 0, 0, 0);
      chk($sformatf("ex_blocked[%0d]", k), 0, 0, 0, 32'h4);
    end
    cyc(0, 1, addi(9), 1, 0, 0, 1);                        chk("ex_flush", 0, 0, 0, 32'h4);
    cyc(0, 0, nd, 1, 0, 0, 0);                             chk("ex_empty", 0, 1, 0, 32'h4);
    cyc(0, 0, nd, 1, 1, 2, 0);                             chk("ex_wb", 0, 1, 0, 32'h4);
    cyc(0, 0, nd, 1, 0, 0, 0);                             chk("ex_drained", 0, 1, 1, 32'h0);

    // Flush of a stalled uop together with an unrelated writeback.
    cyc(0, 1, addi(1), 1, 0, 0, 0);                        chk("fl_a", 0, 1, 1, 32'h0);
    cyc(0, 1, addi(2), 1, 0, 0, 0);                        chk("fl_b", 1, 1, 0, 32'h0);
    cyc(0, 1, add(5,1,2), 1, 0, 0, 0);                     chk("fl_c", 1, 1, 0, 32'h2);
    cyc(0, 0, nd, 1, 0, 0, 0);                             chk("fl_stall", 0, 0, 0, 32'h6);
    cyc(0, 0, nd, 1, 1, 2, 1);                             chk("fl_flush", 0, 0, 0, 32'h6);
    cyc(0, 0, nd, 1, 1, 1, 0);                             chk("fl_after", 0, 1, 0, 32'h2);
    cyc(0, 0, nd, 1, 0, 0, 0);                             chk("fl_drained", 0, 1, 1, 32'h0);

    // Reset while holding a stalled uop with r4..r7 busy.
    cyc(0, 1, addi(4), 1, 0, 0, 0);                        chk("rs_a", 0, 1, 1, 32'h0);
    cyc(0, 1, addi(5), 1, 0, 0, 0);                        chk("rs_b", 1, 1, 0, 32'h0);
    cyc(0, 1, addi(6), 1, 0, 0, 0);                        chk("rs_c", 1, 1, 0, 32'h10);
    cyc(0, 1, addi(7), 1, 0, 0, 0);                        chk("rs_d", 1, 1, 0, 32'h30);
    cyc(0, 1, add(9,4,0), 1, 0, 0, 0);                     chk("rs_e", 1, 1, 0, 32'h70);
    cyc(0, 0, nd, 1, 0, 0, 0);                             chk("rs_held", 0, 0, 0, 32'hF0);
    cyc(1, 0, nd, 1, 0, 0, 0);                             chk("rs_assert", 0, 0, 0, 32'hF0);
    cyc(0, 0, nd, 1, 0, 0, 0);
    check("rs_after", 0, 1, 1, 32'h0, 1'b1, '0);

    // Random traffic against the reference model.
    cyc(1, 0, nd, 0, 0, 0, 0);
    m_have = 0; m_blocked = 0; m_dec = '0;
    foreach (m_busy[j]) m_busy[j] = 0;
    for (int n = 0; n < 3000; n++) begin
      r    = ($urandom_range(0, 99) == 0);
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      wbv  = ($urandom_range(0, 2) == 0);
      wr   = $urandom_range(0, 7);
      fl   = ($urandom_range(0, 24) == 0);
      d    = mk(4'($urandom_range(0, 3)), $urandom_range(0, 7), $urandom_range(0, 7),
                $urandom_range(0, 7), ($urandom_range(0, 15) == 0) ? EX_DECODE : EX_NONE);
      cyc(r, iv, d, ordy, wbv, wr, fl);

      hz   = m_busy[m_dec.rs1] || m_busy[m_dec.rs2] || m_busy[m_dec.rd];
      exc  = (m_dec.ex != EX_NONE);
      eov  = m_have && !fl && (exc || !hz);
      fire = eov && ordy;
      eir  = !fl && !m_blocked && (!m_have || (fire && !exc));
      eb   = '0;
      foreach (m_busy[j]) eb[j] = m_busy[j];
      edr  = !m_have && !m_blocked && (eb == 0);
      check($sformatf("rand[%0d]", n), eov, eir, edr, eb, 1'b1, m_dec);

      if (r) begin
        m_have = 0; m_blocked = 0; m_dec = '0;
        foreach (m_busy[j]) m_busy[j] = 0;
      end else begin
        if (wbv) m_busy[wr] = 0;
        if (fire && !exc && m_dec.rd != 0) m_busy[m_dec.rd] = 1;
        if (fl) begin
          m_have = 0; m_blocked = 0;
        end else if (fire) begin
          m_have = 0; m_blocked = exc;
        end
        if (iv && eir) begin
          m_have = 1; m_dec = d;
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
